idex_vector_issue: RTL and testbench



---
 rtl/pipeline_pkg.sv | 18 +
 rtl/lane_select.sv | 40 ++++
 rtl/idex_vector_issue.sv | 131 +++++++++++++
 tb/tb_idex_vector_issue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: issue FSM states, default geometry and the vector register type.
package pipeline_pkg;

    localparam int DEF_WIDTH        = 24;
    localparam int DEF_ADDRESSWIDTH = 4;
    localparam int DEF_OPCODEWIDTH  = 4;
    localparam int DEF_VECTOR_WIDTH = 8;
    localparam int DEF_LANES        = 2;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SCALAR = 2'd1,
        ST_VECTOR = 2'd2
    } issue_state_t;

    typedef logic [DEF_VECTOR_WIDTH-1:0][DEF_WIDTH-1:0] vector_t;

endpackage

// File: rtl/lane_select.sv
// Combinational slicing of the held vector operands into the current beat's lanes.
module lane_select
    import pipeline_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int LANES        = DEF_LANES,
    parameter int BW           = 2
) (
    input  logic                               is_vector,
    input  logic                               vect_esc,
    input  logic [BW-1:0]                      beat,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data1,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data2,
    input  logic [WIDTH-1:0]                   op2,
    output logic [LANES-1:0][WIDTH-1:0]        lane_a,
    output logic [LANES-1:0][WIDTH-1:0]        lane_b,
    output logic [2:0]                         lane_base
);
    localparam int BEATS = VECTOR_WIDTH / LANES;

    // Same bits regrouped one row per beat, so a beat is a single indexed row.
    logic [BEATS-1:0][LANES*WIDTH-1:0] rows1;
    logic [BEATS-1:0][LANES*WIDTH-1:0] rows2;

    assign rows1 = data1;
    assign rows2 = data2;

    always_comb begin
        lane_a    = '0;
        lane_b    = '0;
        lane_base = '0;
        if (is_vector) begin
            lane_a    = rows1[beat];
            lane_b    = vect_esc ? {LANES{op2}} : rows2[beat];
            lane_base = 3'(int'(beat) * LANES);
        end
    end

endmodule

// File: rtl/idex_vector_issue.sv
// ID/EX issue stage: holds one decoded instruction and issues it as one scalar beat
// or VECTOR_WIDTH/LANES vector beats to execute.
//
// state     | meaning
// EMPTY     | nothing held, ready for decode
// SCALAR    | scalar instruction held, single beat
// VECTOR    | vector instruction held, issuing beat 'beat'
module idex_vector_issue
    import pipeline_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
    parameter int OPCODEWIDTH  = DEF_OPCODEWIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int LANES        = DEF_LANES
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [OPCODEWIDTH-1:0]             opcode_in,
    input  logic [ADDRESSWIDTH-1:0]            regDestinationAddress_in,
    input  logic [WIDTH-1:0]                   reg1Content_in,
    input  logic [WIDTH-1:0]                   reg2Content_in,
    input  logic [WIDTH-1:0]                   inmediate_in,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data_in1,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data_in2,
    input  logic                               isvector_in,
    input  logic                               vect_esc_in,
    input  logic [2:0]                         index_in,
    output logic                               out_valid,
    input  logic                               ex_ready,
    output logic [OPCODEWIDTH-1:0]             opcode_out,
    output logic [ADDRESSWIDTH-1:0]            regDestinationAddress_out,
    output logic                               isvector_out,
    output logic                               vect_esc_out,
    output logic [2:0]                         index_out,
    output logic [WIDTH-1:0]                   op1_out,
    output logic [WIDTH-1:0]                   op2_out,
    output logic [WIDTH-1:0]                   imm_out,
    output logic [LANES-1:0][WIDTH-1:0]        lane_a,
    output logic [LANES-1:0][WIDTH-1:0]        lane_b,
    output logic [2:0]                         lane_base,
    output logic                               last_beat
);
    localparam int BEATS = VECTOR_WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (VECTOR_WIDTH % LANES != 0) begin : g_lanes_check
            $error("LANES must divide VECTOR_WIDTH");
        end
    endgenerate

    issue_state_t                       state;
    logic [BW-1:0]                      beat;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data1;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data2;
    logic                               transfer;
    logic                               accept;

    assign out_valid = (state != ST_EMPTY);
    assign last_beat = (state == ST_SCALAR) ||
                       ((state == ST_VECTOR) && (beat == BW'(BEATS - 1)));
    assign transfer  = out_valid && ex_ready;
    // Refilling on the last transfer keeps scalar instructions flowing one per cycle.
    assign in_ready  = !flush && reset && ((state == ST_EMPTY) || (transfer && last_beat));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                     <= ST_EMPTY;
            beat                      <= '0;
            opcode_out                <= '0;
            regDestinationAddress_out <= '0;
            isvector_out              <= 1'b0;
            vect_esc_out              <= 1'b0;
            index_out                 <= '0;
            op1_out                   <= '0;
            op2_out                   <= '0;
            imm_out                   <= '0;
            data1                     <= '0;
            data2                     <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
            beat  <= '0;
        end else begin
            if (transfer) begin
                if (last_beat) begin
                    state <= ST_EMPTY;
                    beat  <= '0;
                end else begin
                    beat <= beat + BW'(1);
                end
            end
            if (accept) begin
                state                     <= isvector_in ? ST_VECTOR : ST_SCALAR;
                beat                      <= '0;
                opcode_out                <= opcode_in;
                regDestinationAddress_out <= regDestinationAddress_in;
                isvector_out              <= isvector_in;
                vect_esc_out              <= vect_esc_in;
                index_out                 <= index_in;
                op1_out                   <= reg1Content_in;
                op2_out                   <= reg2Content_in;
                imm_out                   <= inmediate_in;
                data1                     <= data_in1;
                data2                     <= data_in2;
            end
        end
    end

    lane_select #(
        .WIDTH        (WIDTH),
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .LANES        (LANES),
        .BW           (BW)
    ) u_lane_select (
        .is_vector (state == ST_VECTOR),
        .vect_esc  (vect_esc_out),
        .beat      (beat),
        .data1     (data1),
        .data2     (data2),
        .op2       (op2_out),
        .lane_a    (lane_a),
        .lane_b    (lane_b),
        .lane_base (lane_base)
    );

endmodule

// File: tb/tb_idex_vector_issue.sv
// Bench for idex_vector_issue: directed scenarios plus random traffic against a
// queue-of-expected-beats scoreboard.
module tb_idex_vector_issue;
    import pipeline_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode_in;
    logic [3:0]    regDestinationAddress_in;
    logic [23:0]   reg1Content_in;
    logic [23:0]   reg2Content_in;
    logic [23:0]   inmediate_in;
    vector_t       data_in1;
    vector_t       data_in2;
    logic          isvector_in;
    logic          vect_esc_in;
    logic [2:0]    index_in;
    logic          out_valid;
    logic          ex_ready;
    logic [3:0]    opcode_out;
    logic [3:0]    regDestinationAddress_out;
    logic          isvector_out;
    logic          vect_esc_out;
    logic [2:0]    index_out;
    logic [23:0]   op1_out;
    logic [23:0]   op2_out;
    logic [23:0]   imm_out;
    logic [1:0][23:0] lane_a;
    logic [1:0][23:0] lane_b;
    logic [2:0]    lane_base;
    logic          last_beat;

    always #5 clock = ~clock;

    idex_vector_issue dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .opcode_in                 (opcode_in),
        .regDestinationAddress_in  (regDestinationAddress_in),
        .reg1Content_in            (reg1Content_in),
        .reg2Content_in            (reg2Content_in),
        .inmediate_in              (inmediate_in),
        .data_in1                  (data_in1),
        .data_in2                  (data_in2),
        .isvector_in               (isvector_in),
        .vect_esc_in               (vect_esc_in),
        .index_in                  (index_in),
        .out_valid                 (out_valid),
        .ex_ready                  (ex_ready),
        .opcode_out                (opcode_out),
        .regDestinationAddress_out (regDestinationAddress_out),
        .isvector_out              (isvector_out),
        .vect_esc_out              (vect_esc_out),
        .index_out                 (index_out),
        .op1_out                   (op1_out),
        .op2_out                   (op2_out),
        .imm_out                   (imm_out),
        .lane_a                    (lane_a),
        .lane_b                    (lane_b),
        .lane_base                 (lane_base),
        .last_beat                 (last_beat)
    );

    // One entry per beat the execute stage is still owed, oldest first.
    typedef struct {
        logic [3:0]  opcode;
        logic [3:0]  dest;
        logic [23:0] op1;
        logic [23:0] op2;
        logic [23:0] imm;
        logic        isv;
        logic        esc;
        logic [2:0]  idx;
        logic [47:0] la;
        logic [47:0] lb;
        logic [2:0]  base;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push_instr();
        beat_t bt;
        bt.opcode = opcode_in;
        bt.dest   = regDestinationAddress_in;
        bt.op1    = reg1Content_in;
        bt.op2    = reg2Content_in;
        bt.imm    = inmediate_in;
        bt.isv    = isvector_in;
        bt.esc    = vect_esc_in;
        bt.idx    = index_in;
        if (!isvector_in) begin
            bt.la   = '0;
            bt.lb   = '0;
            bt.base = '0;
            bt.last = 1'b1;
            q.push_back(bt);
        end else begin
            for (int k = 0; k < 4; k++) begin
                bt.la   = {data_in1[2*k+1], data_in1[2*k]};
                bt.lb   = vect_esc_in ? {reg2Content_in, reg2Content_in}
                                      : {data_in2[2*k+1], data_in2[2*k]};
                bt.base = 3'(2*k);
                bt.last = (k == 3);
                q.push_back(bt);
            end
        end
    endfunction

    function automatic logic exp_ready();
        return !flush && reset && ((q.size() == 0) || (ex_ready && q[0].last));
    endfunction

    // Compare against the scoreboard, advance it for the coming edge, move to the next negedge.
    task automatic step();
        logic er;
        er = exp_ready();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(er));
        if (q.size() != 0) begin
            chk("opcode_out", 64'(opcode_out), 64'(q[0].opcode));
            chk("dest_out", 64'(regDestinationAddress_out), 64'(q[0].dest));
            chk("op1_out", 64'(op1_out), 64'(q[0].op1));
            chk("op2_out", 64'(op2_out), 64'(q[0].op2));
            chk("imm_out", 64'(imm_out), 64'(q[0].imm));
            chk("isvector_out", 64'(isvector_out), 64'(q[0].isv));
            chk("vect_esc_out", 64'(vect_esc_out), 64'(q[0].esc));
            chk("index_out", 64'(index_out), 64'(q[0].idx));
            chk("lane_a", 64'(lane_a), 64'(q[0].la));
            chk("lane_b", 64'(lane_b), 64'(q[0].lb));
            chk("lane_base", 64'(lane_base), 64'(q[0].base));
            chk("last_beat", 64'(last_beat), 64'(q[0].last));
        end
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ex_ready) void'(q.pop_front());
            if (in_valid && er) push_instr();
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic load_instr(input logic isv, input logic esc, input logic [3:0] opc,
                              input logic [23:0] r1, input logic [23:0] r2);
        in_valid                 = 1'b1;
        isvector_in              = isv;
        vect_esc_in              = esc;
        opcode_in                = opc;
        reg1Content_in           = r1;
        reg2Content_in           = r2;
        regDestinationAddress_in = 4'($urandom);
        inmediate_in             = 24'($urandom);
        index_in                 = 3'($urandom);
        for (int k = 0; k < 8; k++) begin
            data_in1[k] = 24'(k + 1);
            data_in2[k] = 24'($urandom);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        opcode_in = '0; regDestinationAddress_in = '0; reg1Content_in = '0;
        reg2Content_in = '0; inmediate_in = '0; data_in1 = '0; data_in2 = '0;
        isvector_in = 1'b0; vect_esc_in = 1'b0; index_in = '0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_op1", 64'(op1_out), 64'd0);
        chk("rst_lane_a", 64'(lane_a), 64'd0);
        chk("rst_last_beat", 64'(last_beat), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // scalar pass
        load_instr(1'b0, 1'b0, 4'h3, 24'h000011, 24'h0);
        #1; step();
        in_valid = 1'b0;
        #1;
        chk("scalar_out_valid", 64'(out_valid), 64'd1);
        chk("scalar_op1", 64'(op1_out), 64'h11);
        chk("scalar_opcode", 64'(opcode_out), 64'h3);
        chk("scalar_last", 64'(last_beat), 64'd1);
        chk("scalar_in_ready", 64'(in_ready), 64'd1);
        step();

        // four-beat vector
        load_instr(1'b1, 1'b0, 4'h5, 24'h1, 24'h2);
        #1; step();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("vec_lane_a", 64'(lane_a), 64'({24'(2*b+2), 24'(2*b+1)}));
            chk("vec_lane_base", 64'(lane_base), 64'(2*b));
            chk("vec_last", 64'(last_beat), 64'(b == 3));
            chk("vec_in_ready", 64'(in_ready), 64'(b == 3));
            step();
        end
        #1; chk("vec_done", 64'(out_valid), 64'd0);
        step();

        // backpressure on the second beat
        load_instr(1'b1, 1'b0, 4'h6, 24'h3, 24'h4);
        #1; step();
        in_valid = 1'b0;
        #1; step();
        ex_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_lane_a", 64'(lane_a), 64'({24'd4, 24'd3}));
            chk("stall_lane_base", 64'(lane_base), 64'd2);
            step();
        end
        ex_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1; step();
        end
        #1; chk("stall_done", 64'(out_valid), 64'd0);
        step();

        // flush at the second beat with a new instruction offered
        load_instr(1'b1, 1'b0, 4'h7, 24'h5, 24'h6);
        #1; step();
        in_valid = 1'b0;
        #1; step();
        load_instr(1'b1, 1'b0, 4'h8, 24'h7, 24'h8);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step();
        load_instr(1'b1, 1'b0, 4'h9, 24'h9, 24'hA);
        #1; step();
        in_valid = 1'b0;
        #1;
        chk("flush_restart_base", 64'(lane_base), 64'd0);
        chk("flush_restart_valid", 64'(out_valid), 64'd1);
        for (int s = 0; s < 4; s++) begin
            #1; step();
        end

        // vector-scalar operand
        load_instr(1'b1, 1'b1, 4'hA, 24'h1, 24'h00000A);
        #1; step();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("esc_lane_b", 64'(lane_b), 64'({24'hA, 24'hA}));
            step();
        end

        // reset in the middle of a vector
        load_instr(1'b1, 1'b0, 4'hB, 24'h55, 24'h66);
        #1; step();
        in_valid = 1'b0;
        #1; step();
        #1; step();
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_lane_a", 64'(lane_a), 64'd0);
        chk("midrst_op1", 64'(op1_out), 64'd0);
        chk("midrst_opcode", 64'(opcode_out), 64'd0);
        chk("midrst_last", 64'(last_beat), 64'd0);
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        load_instr(1'b0, 1'b0, 4'hC, 24'h000123, 24'h0);
        #1; step();
        in_valid = 1'b0;
        #1;
        chk("postrst_op1", 64'(op1_out), 64'h123);
        chk("postrst_last", 64'(last_beat), 64'd1);
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid                 = ($urandom_range(0, 1) == 1);
            ex_ready                 = ($urandom_range(0, 9) < 7);
            flush                    = ($urandom_range(0, 19) == 0);
            isvector_in              = ($urandom_range(0, 1) == 1);
            vect_esc_in              = ($urandom_range(0, 3) == 0);
            opcode_in                = 4'($urandom);
            regDestinationAddress_in = 4'($urandom);
            reg1Content_in           = 24'($urandom);
            reg2Content_in           = 24'($urandom);
            inmediate_in             = 24'($urandom);
            index_in                 = 3'($urandom);
            for (int k = 0; k < 8; k++) begin
                data_in1[k] = 24'($urandom);
                data_in2[k] = 24'($urandom);
            end
            #1; step();
        end
        in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1; step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
